lag_pl_output_port: RTL and testbench
=====================================

LAG_PL_OUTPUT_PORT -- requirements
Module: LAG_pl_output_port

Interface
REQ-001 SHALL have parameter num_pls, default 4: number of output physical channels (PLs).
REQ-002 SHALL have parameter buffer_length, default 8: depth in flits of each downstream input PL buffer, which is also the initial credit count.
REQ-003 SHALL have ports, in this order:
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port push_in  input  num_pls  flit offered on PL i this cycle.
REQ-005 SHALL have port data_in  input  flit_t[num_pls]  offered flits; tail taken from data_in[i].control.tail.
REQ-006 SHALL have port alloc  input  num_pls  PL i granted to a new packet this cycle.
REQ-007 SHALL have port credit_in  input  num_pls  downstream popped one flit from PL i buffer.
REQ-008 SHALL have port push_out  output  num_pls  registered flit-valid toward downstream.
REQ-009 SHALL have port data_out  output  flit_t[num_pls]  registered flits toward downstream.
REQ-010 SHALL have port pl_free  output  num_pls  PL i unallocated and available for allocation.
REQ-011 SHALL have port can_send  output  num_pls  PL i has at least one credit.
REQ-012 SHALL have port error  output  1  sticky protocol-violation flag.

Function
REQ-013 SHALL keep per PL a credit counter of width clog2(buffer_length+1), range 0..buffer_length.
REQ-014 SHALL assert can_send[i] combinationally iff credit[i] > 0.
REQ-015 SHALL accept a flit on PL i when push_in[i] and credit[i] > 0 and pl_free[i] = 0.
REQ-016 SHALL, on acceptance, register data_in[i] into data_out[i] and assert push_out[i] for exactly the next cycle (latency 1).
REQ-017 SHALL deassert push_out[i] in any cycle following no acceptance, and hold data_out[i] unchanged then.
REQ-018 SHALL update credits as follows:
- accept only: decrement by 1.
- credit_in only: increment by 1.
- both in the same cycle: unchanged.
REQ-019 SHALL ignore credit_in[i] when credit[i] = buffer_length with no acceptance, leave credit at buffer_length, and set error.
REQ-020 SHALL drop push_in[i] when credit[i] = 0 or pl_free[i] = 1, leave credits unchanged, emit no flit, and set error.
REQ-021 SHALL run a per-PL two-state FSM, states FREE (pl_free = 1) and BUSY (pl_free = 0), with transitions:
- FREE -> BUSY on alloc[i].
- BUSY -> FREE on acceptance of a tail flit.
- All else: hold.
REQ-022 SHALL, when alloc[i] and an accepted tail coincide while BUSY, go FREE and set error (alloc of busy PL).
REQ-023 SHALL ignore alloc[i] while BUSY, stay BUSY, and set error.
REQ-024 SHALL treat alloc[i] as taking effect next cycle: a flit pushed in the same cycle as alloc from FREE is dropped per REQ-020.
REQ-025 SHALL, once set, hold error at 1 until reset.
REQ-026 SHALL operate all PLs independently with no cross-PL arbitration.

Reset
REQ-027 SHALL, on rst_n low and asynchronously, drive: all credit = buffer_length, all FSMs FREE (pl_free all 1), push_out = 0, data_out = 0, error = 0.
REQ-028 SHALL, with reset asserted mid-packet, discard in-flight state; the first cycle after release behaves as a fresh start.
REQ-029 SHALL drive can_send all 1 during and after reset.

Verification
REQ-030 SHALL cover, after reset, alloc[0] then 3 pushes on PL0 with the last a tail -> push_out[0] high 3 cycles, each 1 cycle after its push; credit[0] = 5; pl_free[0] = 1 after the tail.
REQ-031 SHALL cover 8 accepted pushes with no credit_in, then a 9th push -> can_send[0] = 0 after the 8th; 9th dropped; error = 1.
REQ-032 SHALL cover credit = 3 with accept and credit_in in the same cycle -> credit stays 3; then credit_in alone -> credit 4.
REQ-033 SHALL cover a single-flit packet, alloc cycle N, tail push cycle N+1 -> push_out at N+2; pl_free = 0 at N+1; pl_free = 1 at N+2; error = 0.
REQ-034 SHALL cover push on a FREE PL, and separately credit_in at buffer_length -> no push_out; error = 1 and stays 1 until rst_n low.
REQ-035 SHALL cover rst_n asserted asynchronously mid-packet with credit = 2 -> immediately credit = 8, pl_free = 1, push_out = 0, error = 0.

Source files
------------

// File: rtl/lag_pl_output_port_pkg.sv
// Shared flit format for the LAG physical-link output port and its users.
// Only the tail bit of the control field is interpreted by the port.
package lag_pl_output_port_pkg;

  typedef struct packed {
    logic tail;
  } flit_ctrl_t;

  typedef struct packed {
    flit_ctrl_t  control;
    logic [15:0] data;
  } flit_t;

endpackage

// File: rtl/lag_pl_output_port.sv
// LAG physical-link output port: per-PL credit tracking, FREE/BUSY allocation
// state and a one-cycle registered flit stage toward the downstream buffers.
module lag_pl_output_port
  import lag_pl_output_port_pkg::*;
#(
  parameter int num_pls       = 4,
  parameter int buffer_length = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [num_pls-1:0] push_in,
  input  flit_t              data_in [num_pls],
  input  logic [num_pls-1:0] alloc,
  input  logic [num_pls-1:0] credit_in,
  output logic [num_pls-1:0] push_out,
  output flit_t              data_out [num_pls],
  output logic [num_pls-1:0] pl_free,
  output logic [num_pls-1:0] can_send,
  output logic               error
);

  localparam int              CW       = $clog2(buffer_length + 1);
  localparam logic [CW-1:0]   CRED_MAX = CW'(buffer_length);
  localparam logic [CW-1:0]   CRED_ONE = CW'(1);
  localparam logic [CW-1:0]   CRED_ZERO = CW'(0);

  typedef enum logic {
    ST_FREE = 1'b0,
    ST_BUSY = 1'b1
  } pl_state_t;

  pl_state_t          r_state     [num_pls];
  pl_state_t          w_state_nxt [num_pls];
  logic [CW-1:0]      r_credit    [num_pls];
  logic [CW-1:0]      w_credit_nxt[num_pls];
  logic [num_pls-1:0] w_accept;
  logic [num_pls-1:0] w_viol;

  // Acceptance, credit and allocation next-state for every PL independently.
  always_comb begin
    w_accept = {num_pls{1'b0}};
    w_viol   = {num_pls{1'b0}};
    for (int i = 0; i < num_pls; i++) begin
      w_credit_nxt[i] = r_credit[i];
      w_state_nxt[i]  = r_state[i];
      w_accept[i] = push_in[i] && (r_credit[i] != CRED_ZERO) && (r_state[i] == ST_BUSY);
      // Violations: dropped push, credit overflow, or alloc of a busy PL.
      w_viol[i] = (push_in[i] && !w_accept[i])
               || (credit_in[i] && !w_accept[i] && (r_credit[i] == CRED_MAX))
               || (alloc[i] && (r_state[i] == ST_BUSY));

      case ({w_accept[i], credit_in[i]})
        2'b10: w_credit_nxt[i] = r_credit[i] - CRED_ONE;
        2'b01: begin
          if (r_credit[i] != CRED_MAX) begin
            w_credit_nxt[i] = r_credit[i] + CRED_ONE;
          end else begin
            w_credit_nxt[i] = r_credit[i];
          end
        end
        default: w_credit_nxt[i] = r_credit[i];
      endcase

      case (r_state[i])
        ST_FREE: begin
          if (alloc[i]) begin
            w_state_nxt[i] = ST_BUSY;
          end else begin
            w_state_nxt[i] = ST_FREE;
          end
        end
        ST_BUSY: begin
          if (w_accept[i] && data_in[i].control.tail) begin
            w_state_nxt[i] = ST_FREE;
          end else begin
            w_state_nxt[i] = ST_BUSY;
          end
        end
        default: w_state_nxt[i] = ST_FREE;
      endcase
    end
  end

  // Per-PL state, output flit stage and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_out <= {num_pls{1'b0}};
      error    <= 1'b0;
      for (int i = 0; i < num_pls; i++) begin
        r_state[i]  <= ST_FREE;
        r_credit[i] <= CRED_MAX;
        data_out[i] <= '0;
      end
    end else begin
      push_out <= w_accept;
      error    <= error | (|w_viol);
      for (int i = 0; i < num_pls; i++) begin
        r_state[i]  <= w_state_nxt[i];
        r_credit[i] <= w_credit_nxt[i];
        if (w_accept[i]) begin
          data_out[i] <= data_in[i];
        end
      end
    end
  end

  // Status flags derive straight from registered state.
  always_comb begin
    pl_free  = {num_pls{1'b0}};
    can_send = {num_pls{1'b0}};
    for (int i = 0; i < num_pls; i++) begin
      pl_free[i]  = (r_state[i] == ST_FREE);
      can_send[i] = (r_credit[i] != CRED_ZERO);
    end
  end

endmodule

// File: tb/tb_lag_pl_output_port.sv
// Bench for lag_pl_output_port: directed scenarios then randomized traffic,
// all checked against a credit/allocation reference model kept here.
module tb_lag_pl_output_port;
  import lag_pl_output_port_pkg::*;

  localparam int NP = 4;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] push_in, alloc, credit_in;
  flit_t         data_in  [NP];
  logic [NP-1:0] push_out, pl_free, can_send;
  flit_t         data_out [NP];
  logic          error;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int    m_credit [NP];
  bit    m_busy   [NP];
  bit    m_po     [NP];
  flit_t m_do     [NP];
  bit    m_err;

  lag_pl_output_port #(.num_pls(NP), .buffer_length(BL)) dut (
    .clk(clk), .rst_n(rst_n), .push_in(push_in), .data_in(data_in),
    .alloc(alloc), .credit_in(credit_in), .push_out(push_out),
    .data_out(data_out), .pl_free(pl_free), .can_send(can_send), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_credit[i] = BL;
      m_busy[i]   = 1'b0;
      m_po[i]     = 1'b0;
      m_do[i]     = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("%s.push_out[%0d]", tag, i), 32'(push_out[i]), 32'(m_po[i]));
      chk($sformatf("%s.data_out[%0d]", tag, i), 32'(data_out[i]), 32'(m_do[i]));
      chk($sformatf("%s.pl_free[%0d]", tag, i), 32'(pl_free[i]), 32'(!m_busy[i]));
      chk($sformatf("%s.can_send[%0d]", tag, i), 32'(can_send[i]), 32'(m_credit[i] > 0));
      chk($sformatf("%s.credit[%0d]", tag, i), 32'(dut.r_credit[i]), 32'(m_credit[i]));
    end
    chk($sformatf("%s.error", tag), 32'(error), 32'(m_err));
  endtask

  task automatic idle_inputs();
    push_in   = '0;
    alloc     = '0;
    credit_in = '0;
    for (int i = 0; i < NP; i++) begin
      data_in[i] = '0;
    end
  endtask

  task automatic set_flit(int pl, bit tail);
    data_in[pl].data         = 16'($urandom);
    data_in[pl].control.tail = tail;
  endtask

  // One clock: advance the model from current inputs, then check at negedge.
  task automatic tick(string tag);
    bit acc;
    for (int i = 0; i < NP; i++) begin
      acc = push_in[i] && (m_credit[i] > 0) && m_busy[i];
      if (push_in[i] && !acc) m_err = 1'b1;
      if (alloc[i] && m_busy[i]) m_err = 1'b1;
      if (credit_in[i] && !acc && m_credit[i] == BL) m_err = 1'b1;
      else m_credit[i] = m_credit[i] - int'(acc) + int'(credit_in[i]);
      if (m_busy[i]) m_busy[i] = !(acc && data_in[i].control.tail);
      else           m_busy[i] = alloc[i];
      m_po[i] = acc;
      if (acc) m_do[i] = data_in[i];
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
    idle_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    check_all("por");
    do_reset();

    // Three-flit packet on PL0, tail last.
    alloc[0] = 1'b1; tick("p3_alloc");
    for (int k = 0; k < 3; k++) begin
      push_in[0] = 1'b1; set_flit(0, k == 2); tick("p3_push");
      chk("p3_push_out_lat", 32'(push_out[0]), 32'd1);
    end
    chk("p3_credit", 32'(dut.r_credit[0]), 32'd5);
    chk("p3_free", 32'(pl_free[0]), 32'd1);
    tick("p3_idle");
    chk("p3_po_drop", 32'(push_out[0]), 32'd0);

    // Simultaneous accept and credit return at credit 3.
    alloc[0] = 1'b1; tick("c3_alloc");
    for (int k = 0; k < 2; k++) begin
      push_in[0] = 1'b1; set_flit(0, 1'b0); tick("c3_fill");
    end
    chk("c3_at3", 32'(dut.r_credit[0]), 32'd3);
    push_in[0] = 1'b1; credit_in[0] = 1'b1; set_flit(0, 1'b0); tick("c3_both");
    chk("c3_both", 32'(dut.r_credit[0]), 32'd3);
    credit_in[0] = 1'b1; tick("c3_ret");
    chk("c3_ret", 32'(dut.r_credit[0]), 32'd4);
    chk("c3_err", 32'(error), 32'd0);

    // Exhaust all credits, then one more push is dropped.
    do_reset();
    alloc[0] = 1'b1; tick("ex_alloc");
    for (int k = 0; k < BL; k++) begin
      push_in[0] = 1'b1; set_flit(0, 1'b0); tick("ex_push");
    end
    chk("ex_can_send", 32'(can_send[0]), 32'd0);
    push_in[0] = 1'b1; set_flit(0, 1'b1); tick("ex_9th");
    chk("ex_9th_po", 32'(push_out[0]), 32'd0);
    chk("ex_9th_err", 32'(error), 32'd1);

    // Single-flit packet on PL1.
    do_reset();
    alloc[1] = 1'b1; tick("sf_alloc");
    chk("sf_busy", 32'(pl_free[1]), 32'd0);
    push_in[1] = 1'b1; set_flit(1, 1'b1); tick("sf_tail");
    chk("sf_po", 32'(push_out[1]), 32'd1);
    chk("sf_free", 32'(pl_free[1]), 32'd1);
    chk("sf_err", 32'(error), 32'd0);

    // Push together with alloc from FREE is dropped and flagged.
    do_reset();
    alloc[2] = 1'b1; push_in[2] = 1'b1; set_flit(2, 1'b0); tick("pf_push");
    chk("pf_po", 32'(push_out[2]), 32'd0);
    chk("pf_err", 32'(error), 32'd1);
    for (int k = 0; k < 3; k++) tick("pf_hold");
    chk("pf_sticky", 32'(error), 32'd1);

    // Credit return while already full.
    do_reset();
    credit_in[3] = 1'b1; tick("ov_ret");
    chk("ov_credit", 32'(dut.r_credit[3]), 32'(BL));
    chk("ov_err", 32'(error), 32'd1);
    for (int k = 0; k < 3; k++) tick("ov_hold");

    // Alloc of a busy PL, also coinciding with its tail.
    do_reset();
    alloc[1] = 1'b1; tick("ab_alloc");
    alloc[1] = 1'b1; tick("ab_busy");
    chk("ab_err", 32'(error), 32'd1);
    alloc[1] = 1'b1; push_in[1] = 1'b1; set_flit(1, 1'b1); tick("ab_tail");
    chk("ab_free", 32'(pl_free[1]), 32'd1);

    // Asynchronous reset mid-packet at credit 2.
    do_reset();
    alloc[0] = 1'b1; tick("ar_alloc");
    for (int k = 0; k < BL - 2; k++) begin
      push_in[0] = 1'b1; set_flit(0, 1'b0); tick("ar_push");
    end
    push_in[1] = 1'b1; tick("ar_errset");
    chk("ar_pre", 32'(dut.r_credit[0]), 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("ar_async");
    @(negedge clk);
    rst_n = 1'b1;
    alloc[0] = 1'b1; tick("ar_fresh");

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
      for (int i = 0; i < NP; i++) begin
        alloc[i]     = ($urandom_range(0, 7) == 0);
        push_in[i]   = ($urandom_range(0, 2) != 0);
        credit_in[i] = (m_credit[i] < BL) ? ($urandom_range(0, 1) == 1)
                                          : ($urandom_range(0, 31) == 0);
        set_flit(i, $urandom_range(0, 3) == 0);
      end
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
